// File: rtl/wb_arbiter_if.sv
// Wishbone classic single-beat bus bundle shared by all arbiter ports.
// MASTER drives the request fields; SLAVE drives ack and read data.
interface wishbone #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0]   adr;
    logic [XLEN-1:0]   dat_w;
    logic [XLEN-1:0]   dat_r;
    logic [XLEN/8-1:0] sel;
    logic              we;
    logic              cyc;
    logic              stb;
    logic              ack;

    modport MASTER (
        output adr, dat_w, sel, we, cyc, stb,
        input  dat_r, ack
    );

    modport SLAVE (
        input  adr, dat_w, sel, we, cyc, stb,
        output dat_r, ack
    );
endinterface

// File: rtl/wb_arbiter.sv
// Two-master to one-slave Wishbone classic arbiter.
// Master 0 is the core instruction port, master 1 the core data port.
// A grant is held for the whole bus cycle (cyc) and is never preempted.
// Optional build macro WB_ARB_RR_EN: when defined, ties are resolved
// round-robin (the master that did not own last wins); when undefined,
// the data port always wins a tie.
module wb_arbiter #(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       rst,
    wishbone.SLAVE     instr_bus,
    wishbone.SLAVE     data_bus,
    wishbone.MASTER    mem_bus,
    output logic [1:0] grant
);

    localparam int SELW = XLEN / 8;

    // Encoding equals the one-hot grant value, so grant is the state register.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_I = 2'b01,
        OWN_D = 2'b10
    } state_t;

    state_t state_reg;
    state_t state_next;
    state_t pick;
    logic   decide;

`ifdef WB_ARB_RR_EN
    state_t last_owner_reg;
`endif

    assign grant = state_reg;

    // State register: reset to IDLE, otherwise take the arbitration result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

`ifdef WB_ARB_RR_EN
    // Remember who was granted most recently so the next tie goes the other way.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner_reg <= OWN_I;
        end else if (decide && (pick != IDLE)) begin
            last_owner_reg <= pick;
        end
    end
`endif

    // Next-state: arbitrate only when idle or when the current owner has released cyc.
    always_comb begin
        decide     = 1'b0;
        pick       = IDLE;
        state_next = state_reg;

        case (state_reg)
            IDLE:    decide = 1'b1;
            OWN_I:   decide = !instr_bus.cyc;
            OWN_D:   decide = !data_bus.cyc;
            default: decide = 1'b1;
        endcase

        if (instr_bus.cyc && data_bus.cyc) begin
`ifdef WB_ARB_RR_EN
            pick = (last_owner_reg == OWN_I) ? OWN_D : OWN_I;
`else
            pick = OWN_D;
`endif
        end else if (data_bus.cyc) begin
            pick = OWN_D;
        end else if (instr_bus.cyc) begin
            pick = OWN_I;
        end else begin
            pick = IDLE;
        end

        if (decide) begin
            state_next = pick;
        end
    end

    // Routing: the owner's request reaches the slave, only the owner sees ack/dat_r.
    always_comb begin
        mem_bus.adr     = {XLEN{1'b0}};
        mem_bus.dat_w   = {XLEN{1'b0}};
        mem_bus.sel     = {SELW{1'b0}};
        mem_bus.we      = 1'b0;
        mem_bus.cyc     = 1'b0;
        mem_bus.stb     = 1'b0;
        instr_bus.ack   = 1'b0;
        instr_bus.dat_r = {XLEN{1'b0}};
        data_bus.ack    = 1'b0;
        data_bus.dat_r  = {XLEN{1'b0}};

        case (state_reg)
            OWN_I: begin
                mem_bus.adr     = instr_bus.adr;
                mem_bus.dat_w   = instr_bus.dat_w;
                mem_bus.sel     = instr_bus.sel;
                mem_bus.we      = instr_bus.we;
                mem_bus.cyc     = instr_bus.cyc;
                mem_bus.stb     = instr_bus.stb;
                instr_bus.ack   = mem_bus.ack;
                instr_bus.dat_r = mem_bus.dat_r;
            end
            OWN_D: begin
                mem_bus.adr     = data_bus.adr;
                mem_bus.dat_w   = data_bus.dat_w;
                mem_bus.sel     = data_bus.sel;
                mem_bus.we      = data_bus.we;
                mem_bus.cyc     = data_bus.cyc;
                mem_bus.stb     = data_bus.stb;
                data_bus.ack    = mem_bus.ack;
                data_bus.dat_r  = mem_bus.dat_r;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: the driver applies one cycle of stimulus,
// predicts that cycle's outputs from a behavioural model and queues them;
// a monitor on the falling edge pops and compares every field.
module tb_wb_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] grant;

    wishbone #(.XLEN(32)) ibus ();
    wishbone #(.XLEN(32)) dbus ();
    wishbone #(.XLEN(32)) mbus ();

    wb_arbiter #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .instr_bus (ibus),
        .data_bus  (dbus),
        .mem_bus   (mbus),
        .grant     (grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          cyc;
        bit          stb;
        bit          we;
        logic [31:0] adr;
        logic [31:0] dw;
        logic [3:0]  sel;
    } mreq_t;

    typedef struct {
        logic [1:0]  grant;
        logic        cyc;
        logic        stb;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dw;
        logic [3:0]  sel;
        logic        iack;
        logic [31:0] idr;
        logic        dack;
        logic [31:0] ddr;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Model state: owner 0 = nobody, 1 = instr, 2 = data; last = last granted.
    int owner       = 0;
    int last        = 1;
    bit model_valid = 1'b0;

    mreq_t none_req = '{cyc: 0, stb: 0, we: 0, adr: 32'h0, dw: 32'h0, sel: 4'h0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: the DUT presents a full set of outputs every cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("grant",     {30'd0, grant},     {30'd0, e.grant});
            chk("mem_cyc",   {31'd0, mbus.cyc},  {31'd0, e.cyc});
            chk("mem_stb",   {31'd0, mbus.stb},  {31'd0, e.stb});
            chk("mem_we",    {31'd0, mbus.we},   {31'd0, e.we});
            chk("mem_adr",   mbus.adr,           e.adr);
            chk("mem_dat_w", mbus.dat_w,         e.dw);
            chk("mem_sel",   {28'd0, mbus.sel},  {28'd0, e.sel});
            chk("i_ack",     {31'd0, ibus.ack},  {31'd0, e.iack});
            chk("i_dat_r",   ibus.dat_r,         e.idr);
            chk("d_ack",     {31'd0, dbus.ack},  {31'd0, e.dack});
            chk("d_dat_r",   dbus.dat_r,         e.ddr);
            $display("cycle t=%0t grant=%b exp=%b mem_cyc=%b i_ack=%b d_ack=%b",
                     $time, grant, e.grant, mbus.cyc, ibus.ack, dbus.ack);
        end
    end

    // One clock cycle of stimulus; called just after a rising edge.
    task automatic apply(input bit r, input mreq_t i, input mreq_t d,
                         input bit sack, input logic [31:0] sdat);
        exp_t  e;
        mreq_t o;
        int    nxt_owner;
        int    nxt_last;
        int    win;
        bit    owner_cyc;

        rst        = r;
        ibus.cyc   = i.cyc;  ibus.stb = i.stb;  ibus.we = i.we;
        ibus.adr   = i.adr;  ibus.dat_w = i.dw; ibus.sel = i.sel;
        dbus.cyc   = d.cyc;  dbus.stb = d.stb;  dbus.we = d.we;
        dbus.adr   = d.adr;  dbus.dat_w = d.dw; dbus.sel = d.sel;
        mbus.ack   = sack;
        mbus.dat_r = sdat;

        if (model_valid) begin
            o = (owner == 1) ? i : (owner == 2) ? d : none_req;
            e.grant = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
            e.cyc   = o.cyc;
            e.stb   = o.stb;
            e.we    = o.we;
            e.adr   = o.adr;
            e.dw    = o.dw;
            e.sel   = o.sel;
            e.iack  = (owner == 1) ? sack : 1'b0;
            e.idr   = (owner == 1) ? sdat : 32'h0;
            e.dack  = (owner == 2) ? sack : 1'b0;
            e.ddr   = (owner == 2) ? sdat : 32'h0;
            q.push_back(e);
        end

        nxt_owner = owner;
        nxt_last  = last;
        owner_cyc = (owner == 1) ? i.cyc : (owner == 2) ? d.cyc : 1'b0;
        if (r) begin
            nxt_owner = 0;
            nxt_last  = 1;
        end else if (!owner_cyc) begin
            if (i.cyc && d.cyc) begin
`ifdef WB_ARB_RR_EN
                win = 3 - last;
`else
                win = 2;
`endif
            end else if (d.cyc) begin
                win = 2;
            end else if (i.cyc) begin
                win = 1;
            end else begin
                win = 0;
            end
            nxt_owner = win;
            if (win != 0) nxt_last = win;
        end

        @(posedge clk);
        owner = nxt_owner;
        last  = nxt_last;
        if (r) model_valid = 1'b1;
        #1;
    endtask

    function automatic mreq_t mk(input bit c, input bit w, input logic [31:0] a,
                                 input logic [31:0] dw, input logic [3:0] s);
        mreq_t m;
        m.cyc = c; m.stb = c; m.we = w; m.adr = a; m.dw = dw; m.sel = s;
        return m;
    endfunction

    initial begin
        mreq_t ird;
        mreq_t dst;
        mreq_t ri;
        mreq_t rd;
        int    li;
        int    ld;

        rst = 1'b1;
        ibus.cyc = 0; ibus.stb = 0; ibus.we = 0; ibus.adr = 0; ibus.dat_w = 0; ibus.sel = 0;
        dbus.cyc = 0; dbus.stb = 0; dbus.we = 0; dbus.adr = 0; dbus.dat_w = 0; dbus.sel = 0;
        mbus.ack = 0; mbus.dat_r = 0;
        @(posedge clk);
        #1;

        ird = mk(1, 0, 32'h0000_0100, 32'h0, 4'hF);
        dst = mk(1, 1, 32'h0000_2000, 32'hCAFE_BABE, 4'b0011);

        // Reset held with both masters requesting, then released: data wins first.
        repeat (3) apply(1, ird, dst, 0, 32'h0);
        apply(0, ird, dst, 0, 32'h0);
        apply(0, ird, dst, 0, 32'h0);
        // Data store completes with ack while instr waits; zero-bubble handover.
        apply(0, ird, dst, 1, 32'h0);
        apply(0, ird, none_req, 0, 32'h0);
        apply(0, ird, none_req, 0, 32'h0);
        apply(0, ird, none_req, 1, 32'h0000_0013);
        apply(0, none_req, none_req, 0, 32'h0);

        // Instruction read at 0x100 from idle, acked after three cycles.
        apply(0, ird, none_req, 0, 32'h0);
        apply(0, ird, none_req, 0, 32'h0);
        apply(0, ird, none_req, 0, 32'h0);
        apply(0, ird, none_req, 1, 32'h0000_0013);
        apply(0, none_req, none_req, 0, 32'h0);

        // Data owns; instr requests mid-cycle and takes over when data drops cyc.
        apply(0, none_req, dst, 0, 32'h0);
        apply(0, ird, dst, 0, 32'h0);
        apply(0, ird, dst, 0, 32'h0);
        apply(0, ird, none_req, 0, 32'h0);
        apply(0, ird, none_req, 1, 32'h1234_5678);
        apply(0, none_req, none_req, 0, 32'h0);

        // Repeated ties from idle: fixed build keeps data, round-robin alternates.
        repeat (4) begin
            apply(0, ird, dst, 0, 32'h0);
            apply(0, ird, dst, 1, 32'hA5A5_0000);
            apply(0, none_req, none_req, 0, 32'h0);
        end

        // Reset while instr owns with stb high and no ack; later ack is not forwarded.
        apply(0, ird, none_req, 0, 32'h0);
        apply(0, ird, none_req, 0, 32'h0);
        apply(1, ird, none_req, 0, 32'h0);
        apply(0, none_req, none_req, 1, 32'hDEAD_BEEF);
        apply(0, none_req, none_req, 1, 32'hDEAD_BEEF);

        // Randomized traffic, slave acks and occasional resets.
        li = 0;
        ld = 0;
        ri = none_req;
        rd = none_req;
        repeat (2000) begin
            if (li == 0) begin
                ri = mk($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                        $urandom, $urandom, 4'($urandom));
                ri.stb = ri.cyc && ($urandom_range(0, 3) != 0);
                li = $urandom_range(1, 5);
            end
            if (ld == 0) begin
                rd = mk($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                        $urandom, $urandom, 4'($urandom));
                rd.stb = rd.cyc && ($urandom_range(0, 3) != 0);
                ld = $urandom_range(1, 5);
            end
            apply($urandom_range(0, 199) == 0, ri, rd,
                  $urandom_range(0, 2) == 0, $urandom);
            li--;
            ld--;
        end

        apply(0, none_req, none_req, 0, 32'h0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
